monster_sprite_renderer: RTL and testbench

- Display-side consumer of the packed monster state bus produced by the game state machine.
- Snapshots state_monsters once per video frame and tests each scanned pixel against all 12 monster boxes.
- Emits a hit flag, the winning monster index and a sprite-ROM address to the pixel mux.
- Sits between the game logic and the VGA timing/colour path, on the pixel clock.

---
 rtl/monster_sprite_renderer.sv | 192 +++++++++++++++++++
 tb/tb_monster_sprite_renderer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monster_sprite_renderer.sv
// -----------------------------------------------------------------------------
// monster_sprite_renderer
//
// Display-side consumer of the packed monster state bus. Once per frame the
// monster records are snapshotted into a shadow register; every scanned pixel
// is then tested against all monster boxes in a two-stage pipeline. The result
// (hit flag, winning monster index, sprite-ROM address) goes to the pixel mux.
//
// Ports:
//   clk_vga        in   1    pixel clock, the only clock
//   rst            in   1    synchronous active-high reset
//   state_monsters in   19*MONSTERS  record i at [19i+18:19i]:
//                               bit0 present, [2:1] dir, [10:3] x, [18:11] y
//   alive          in   1    game running; low at snapshot hides all monsters
//   frame_start    in   1    one-cycle pulse at start of vertical blanking
//   pix_valid      in   1    pix_x/pix_y are an active-area pixel
//   pix_x          in   10   screen column
//   pix_y          in   10   screen row
//   hit            out  1    pixel covered by a monster sprite
//   hit_idx        out  4    lowest-index covering monster (0 when no hit)
//   sprite_addr    out  10   {dir, dy[3:0], dx[3:0]} (0 when no hit)
//   out_valid      out  1    pix_valid delayed two cycles
//   monsters_shown out  4    present records in the current snapshot
//
// Optional feature macro: MONSTER_SPRITE_FLIP_EN
//   When defined, left-moving monsters (dir 2'b10) read the sprite mirrored
//   horizontally (dx replaced by SPRITE-1-dx).
// -----------------------------------------------------------------------------
module monster_sprite_renderer #(
  parameter int unsigned MONSTERS = 12,
  parameter int unsigned SCALE_SH = 2,
  parameter int unsigned X_OFF    = 48,
  parameter int unsigned Y_OFF    = 0,
  parameter int unsigned SPRITE   = 16
) (
  input  logic                   clk_vga,
  input  logic                   rst,
  input  logic [19*MONSTERS-1:0] state_monsters,
  input  logic                   alive,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  output logic                   hit,
  output logic [3:0]             hit_idx,
  output logic [9:0]             sprite_addr,
  output logic                   out_valid,
  output logic [3:0]             monsters_shown
);

  localparam int unsigned SGN_W  = 11;  // signed pixel offset width
  localparam int unsigned G_W    = 9;   // game-space compare width (no wrap at 255)
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFS_W  = 4;   // sprite-local dx/dy field width
  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [1:0] dir;
    logic       present;
  } mon_rec_t;

  // Shadow snapshot of the monster bus, held for a whole frame.
  mon_rec_t [MONSTERS-1:0] snap_q;
  mon_rec_t [MONSTERS-1:0] snap_d;
  logic     [IDX_W-1:0]    shown_d;

  // Stage-1 registers.
  logic             s1_valid;
  logic             s1_in_area;
  logic [G_W-1:0]   s1_gx;
  logic [G_W-1:0]   s1_gy;

  // Stage-1 combinational results.
  logic [SGN_W-1:0] dx_s;
  logic [SGN_W-1:0] dy_s;
  logic             in_area_d;
  logic [G_W-1:0]   gx_d;
  logic [G_W-1:0]   gy_d;

  // Stage-2 combinational results.
  logic [MONSTERS-1:0] match;
  logic                hit_d;
  logic [IDX_W-1:0]    win;
  mon_rec_t            sel;
  logic [OFS_W-1:0]    dx_off;
  logic [OFS_W-1:0]    dy_off;
  logic [IDX_W-1:0]    hit_idx_d;
  logic [ADDR_W-1:0]   addr_d;

  // Next snapshot: reload on frame_start, masking presence when the game is idle.
  // Stage 2 reads this value so a coincident frame_start is already visible.
  always_comb begin
    snap_d = snap_q;
    if (frame_start) begin
      snap_d = state_monsters;
      if (!alive) begin
        for (int i = 0; i < MONSTERS; i++) begin
          snap_d[i].present = 1'b0;
        end
      end
    end
  end

  // Population count of present records in the next snapshot.
  always_comb begin
    shown_d = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      shown_d = shown_d + IDX_W'(snap_d[i].present);
    end
  end

  // Screen to game-space transform; negative offsets fall outside the play area.
  always_comb begin
    dx_s      = {1'b0, pix_x} - SGN_W'(X_OFF);
    dy_s      = {1'b0, pix_y} - SGN_W'(Y_OFF);
    in_area_d = !dx_s[SGN_W-1] && !dy_s[SGN_W-1];
    gx_d      = G_W'(dx_s >> SCALE_SH);
    gy_d      = G_W'(dy_s >> SCALE_SH);
  end

  // Per-monster box test against the stage-1 game coordinates.
  always_comb begin
    match = '0;
    for (int i = 0; i < MONSTERS; i++) begin
      match[i] = snap_d[i].present && s1_in_area && s1_valid &&
                 (s1_gx >= {1'b0, snap_d[i].x}) &&
                 (s1_gx <= {1'b0, snap_d[i].x} + G_W'(SPRITE - 1)) &&
                 (s1_gy >= {1'b0, snap_d[i].y}) &&
                 (s1_gy <= {1'b0, snap_d[i].y} + G_W'(SPRITE - 1));
    end
  end

  // Fixed-priority select: scanning downward leaves the lowest matching index.
  always_comb begin
    win = '0;
    for (int i = MONSTERS - 1; i >= 0; i--) begin
      if (match[i]) begin
        win = IDX_W'(i);
      end
    end
  end

  // Sprite-local address of the winning monster.
  always_comb begin
    hit_d  = |match;
    sel    = snap_d[win];
    dx_off = OFS_W'(s1_gx - {1'b0, sel.x});
    dy_off = OFS_W'(s1_gy - {1'b0, sel.y});
`ifdef MONSTER_SPRITE_FLIP_EN
    // Left-movers reuse the right-facing image mirrored horizontally.
    if (sel.dir == 2'b10) begin
      dx_off = OFS_W'(SPRITE - 1) - dx_off;
    end
`endif
    hit_idx_d = '0;
    addr_d    = '0;
    if (hit_d) begin
      hit_idx_d = win;
      addr_d    = {sel.dir, dy_off, dx_off};
    end
  end

  // Snapshot, stage-1 and stage-2 registers.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      snap_q         <= '0;
      monsters_shown <= '0;
      s1_valid       <= 1'b0;
      s1_in_area     <= 1'b0;
      s1_gx          <= '0;
      s1_gy          <= '0;
      hit            <= 1'b0;
      hit_idx        <= '0;
      sprite_addr    <= '0;
      out_valid      <= 1'b0;
    end else begin
      snap_q         <= snap_d;
      monsters_shown <= shown_d;
      s1_valid       <= pix_valid;
      s1_in_area     <= in_area_d;
      s1_gx          <= gx_d;
      s1_gy          <= gy_d;
      hit            <= hit_d;
      hit_idx        <= hit_idx_d;
      sprite_addr    <= addr_d;
      out_valid      <= s1_valid;
    end
  end

endmodule

// File: tb/tb_monster_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_monster_sprite_renderer
//
// Scoreboard bench: every driven pixel slot pushes its expected result, which
// is popped and compared two cycles later. Expectations come from a screen-
// space model (box = 64x64 pixels at (48+4x, 4y)) of the frame snapshot.
// -----------------------------------------------------------------------------
module tb_monster_sprite_renderer;

  logic         clk_vga = 1'b0;
  logic         rst = 1'b1;
  logic [227:0] state_monsters = '0;
  logic         alive = 1'b0;
  logic         frame_start = 1'b0;
  logic         pix_valid = 1'b0;
  logic [9:0]   pix_x = '0;
  logic [9:0]   pix_y = '0;
  logic         hit;
  logic [3:0]   hit_idx;
  logic [9:0]   sprite_addr;
  logic         out_valid;
  logic [3:0]   monsters_shown;

  monster_sprite_renderer dut (
    .clk_vga        (clk_vga),
    .rst            (rst),
    .state_monsters (state_monsters),
    .alive          (alive),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .hit            (hit),
    .hit_idx        (hit_idx),
    .sprite_addr    (sprite_addr),
    .out_valid      (out_valid),
    .monsters_shown (monsters_shown)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic       v;
    logic       h;
    logic [3:0] idx;
    logic [9:0] addr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Game-side records (what the bus carries) and the bench's frame snapshot.
  int g_pres[12], g_dir[12], g_x[12], g_y[12];
  int m_pres[12], m_dir[12], m_x[12], m_y[12];

  function automatic exp_t model(input logic v, input int x, input int y);
    exp_t r;
    int   dx, dy, bx, by;
    r   = '0;
    r.v = v;
    if (v) begin
      for (int i = 11; i >= 0; i--) begin
        bx = 48 + 4 * m_x[i];
        by = 4 * m_y[i];
        if (m_pres[i] != 0 && x >= bx && x < bx + 64 && y >= by && y < by + 64) begin
          dx = (x - bx) / 4;
          dy = (y - by) / 4;
`ifdef MONSTER_SPRITE_FLIP_EN
          if (m_dir[i] == 2) dx = 15 - dx;
`endif
          r.h    = 1'b1;
          r.idx  = 4'(i);
          r.addr = 10'(m_dir[i] * 256 + dy * 16 + dx);
        end
      end
    end
    return r;
  endfunction

  function automatic logic [227:0] pack_game();
    logic [227:0] v;
    v = '0;
    for (int i = 0; i < 12; i++) begin
      v[19*i +: 19] = {8'(g_y[i]), 8'(g_x[i]), 2'(g_dir[i]), 1'(g_pres[i])};
    end
    return v;
  endfunction

  function automatic int shown_model();
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) if (m_pres[i] != 0) n++;
    return n;
  endfunction

  function automatic void clear_game();
    for (int i = 0; i < 12; i++) begin
      g_pres[i] = 0; g_dir[i] = 0; g_x[i] = 0; g_y[i] = 0;
    end
  endfunction

  // One pixel slot: compare the result due now, then drive the next slot.
  task automatic cycle(input logic v, input int x, input int y, input logic fs, input logic rs);
    exp_t e;
    @(negedge clk_vga);
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (out_valid !== e.v) begin
        bad++; $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, e.v);
      end
      total++;
      if (hit !== e.h) begin
        bad++; $display("FAIL hit t=%0t got=%b want=%b", $time, hit, e.h);
      end
      total++;
      if (hit_idx !== e.idx) begin
        bad++; $display("FAIL hit_idx t=%0t got=%0d want=%0d", $time, hit_idx, e.idx);
      end
      total++;
      if (sprite_addr !== e.addr) begin
        bad++; $display("FAIL sprite_addr t=%0t got=%b want=%b", $time, sprite_addr, e.addr);
      end
    end
    rst         = rs;
    frame_start = fs;
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    if (fs) begin
      for (int i = 0; i < 12; i++) begin
        m_pres[i] = alive ? g_pres[i] : 0;
        m_dir[i] = g_dir[i]; m_x[i] = g_x[i]; m_y[i] = g_y[i];
      end
    end
    if (rs) begin
      q.delete();
      q.push_back('0);
      for (int i = 0; i < 12; i++) m_pres[i] = 0;
    end
    q.push_back(model(v, x, y));
  endtask

  task automatic scan(input int x, input int y);
    cycle(1'b1, x, y, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_shown(input string name);
    total++;
    if (monsters_shown !== 4'(shown_model())) begin
      bad++;
      $display("FAIL %s monsters_shown got=%0d want=%0d", name, monsters_shown, shown_model());
    end
  endtask

  // Drain in-flight pixels, load a new snapshot, then verify the population.
  task automatic frame(input logic al, input string name);
    idle(2);
    state_monsters = pack_game();
    alive          = al;
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    idle(1);
    check_shown(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk_vga);
    total++;
    if ({out_valid, hit, hit_idx, sprite_addr, monsters_shown} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {out_valid, hit, hit_idx, sprite_addr, monsters_shown});
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) m_pres[i] = 0;
    q.push_back('0);
    q.push_back('0);
  endtask

  task automatic test_basic();
    clear_game();
    g_pres[0] = 1; g_dir[0] = 3; g_x[0] = 14; g_y[0] = 105;
    frame(1'b1, "basic_shown");
    scan(104, 420);   // top-left, addr 11_0000_0000
    scan(164, 480);   // bottom-right, addr 11_1111_1111
    scan(168, 420);   // dx = 16
    scan(103, 420);   // one pixel left of box
    scan(104, 484);   // dy = 16
    scan(107, 423);   // still dx=dy=0 within a 4x4 pixel block
    idle(2);
    // Game side changes without frame_start must not affect this frame.
    clear_game();
    state_monsters = pack_game();
    scan(104, 420);
    scan(130, 450);
    idle(2);
  endtask

  task automatic test_priority();
    clear_game();
    g_pres[3] = 1; g_x[3] = 73; g_y[3] = 127;
    g_pres[7] = 1; g_x[7] = 73; g_y[7] = 127;
    frame(1'b1, "prio_shown");
    scan(350, 520);   // inside both -> index 3
    g_pres[3] = 0;
    frame(1'b1, "prio_shown2");
    scan(350, 520);   // only 7 left
    idle(2);
  endtask

  task automatic test_alive();
    clear_game();
    g_pres[5] = 1; g_dir[5] = 1; g_x[5] = 40; g_y[5] = 40;
    frame(1'b0, "dead_shown");
    scan(48 + 160, 160);
    scan(48 + 170, 170);
    // Mid-frame bus change with alive back high, no frame_start.
    g_pres[1] = 1; g_x[1] = 40; g_y[1] = 40;
    state_monsters = pack_game();
    alive = 1'b1;
    scan(48 + 160, 160);
    idle(2);
    check_shown("dead_shown_hold");
  endtask

  task automatic test_area_reset();
    clear_game();
    g_pres[0] = 1; g_dir[0] = 2; g_x[0] = 0; g_y[0] = 0;
    frame(1'b1, "area_shown");
    scan(20, 10);     // left of play area
    scan(47, 0);      // one pixel left of origin
    scan(48, 0);      // origin -> hit
    // Two valid pixels in flight, then reset discards them.
    scan(52, 4);
    scan(56, 8);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    idle(2);
    check_shown("reset_shown");
    scan(52, 4);      // snapshot cleared: no hit until next frame
    idle(2);
  endtask

  task automatic test_flip();
    clear_game();
    g_pres[2] = 1; g_dir[2] = 2; g_x[2] = 131; g_y[2] = 10;
    g_pres[4] = 1; g_dir[4] = 1; g_x[4] = 200; g_y[4] = 100;
    frame(1'b1, "flip_shown");
    scan(48 + 524, 40);       // dir 10, dx 0
    scan(48 + 528, 44);       // dir 10, dx 1
    scan(48 + 800 + 8, 400);  // dir 01, dx 2, never mirrored
    idle(2);
  endtask

  task automatic test_back_to_back();
    clear_game();
    g_pres[0] = 1; g_dir[0] = 1; g_x[0] = 20; g_y[0] = 30;
    g_pres[9] = 1; g_dir[9] = 3; g_x[9] = 30; g_y[9] = 40;
    g_pres[11] = 1; g_dir[11] = 2; g_x[11] = 230; g_y[11] = 240;
    frame(1'b1, "b2b_shown");
    for (int x = 120; x < 240; x += 3) scan(x, 166);
    for (int k = 0; k < 40; k++) scan(int'($urandom_range(100, 1023)), int'($urandom_range(100, 1023)));
    idle(2);
  endtask

  initial begin
    clear_game();
    test_reset();
    test_basic();
    test_priority();
    test_alive();
    test_area_reset();
    test_flip();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
